// File: rtl/cvp14_mem_responder.sv
// System memory for the vector processor bus: preload phase, one-word-per-cycle
// reads/writes in RUN, and a sticky fault state for protocol violations.
module cvp14_mem_responder #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 4096
) (
    input  logic          Clk1,
    input  logic          Reset,
    input  logic [AW-1:0] Addr,
    input  logic          RD,
    input  logic          WR,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [DW-1:0] LdData,
    input  logic          LdDone,
    input  logic          ErrClr,
    output logic          Ready,
    output logic          Err,
    output logic [15:0]   RdCount,
    output logic [15:0]   WrCount
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {LOAD, RUN, FAULT} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [DEPTH];

    logic          addr_ok, ld_addr_ok;
    logic          rd_ok, wr_ok, ld_ok, bus_fault;
    logic          mem_we;
    logic [IW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Compare one bit wider so a DEPTH equal to 2**AW still fits
    assign addr_ok    = ({1'b0, Addr}   < (AW+1)'(DEPTH));
    assign ld_addr_ok = ({1'b0, LdAddr} < (AW+1)'(DEPTH));

    assign rd_ok     = (state == RUN) && RD && !WR && addr_ok;
    assign wr_ok     = (state == RUN) && WR && !RD && addr_ok;
    assign ld_ok     = (state == LOAD) && LdEn && ld_addr_ok;
    assign bus_fault = (state == RUN) && ((RD && WR) || ((RD || WR) && !addr_ok));

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (LdDone) state_nxt = RUN;
            RUN:     if (bus_fault) state_nxt = FAULT;
            FAULT:   if (ErrClr) state_nxt = RUN;
            default: state_nxt = LOAD;
        endcase
    end

    // Preload and bus writes share the single port; state guarantees exclusivity
    always_comb begin
        mem_we    = wr_ok || ld_ok;
        mem_addr  = wr_ok ? Addr[IW-1:0] : (ld_ok ? LdAddr[IW-1:0] : Addr[IW-1:0]);
        mem_wdata = wr_ok ? DataIn : LdData;
    end

    always_ff @(posedge Clk1) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state   <= LOAD;
            DataOut <= '0;
            Ready   <= 1'b0;
            Err     <= 1'b0;
            RdCount <= '0;
            WrCount <= '0;
        end else begin
            state <= state_nxt;
            Ready <= (state_nxt == RUN);
            Err   <= (state_nxt == FAULT);
            if (rd_ok) begin
                DataOut <= mem[mem_addr];
                RdCount <= sat_inc(RdCount);
            end
            if (wr_ok)
                WrCount <= sat_inc(WrCount);
        end
    end

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Directed bench for cvp14_mem_responder: preload, bursts, fault trapping
// and asynchronous reset in the middle of a write burst.
module tb_cvp14_mem_responder;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic [15:0] Addr;
    logic        RD, WR;
    logic [15:0] DataIn, DataOut;
    logic        LdEn;
    logic [15:0] LdAddr, LdData;
    logic        LdDone, ErrClr;
    logic        Ready, Err;
    logic [15:0] RdCount, WrCount;

    int n_vec = 0;
    int n_err = 0;

    int exp_rd = 0;
    int exp_wr = 0;

    cvp14_mem_responder #(.DW(16), .AW(16), .DEPTH(4096)) dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .LdEn    (LdEn),
        .LdAddr  (LdAddr),
        .LdData  (LdData),
        .LdDone  (LdDone),
        .ErrClr  (ErrClr),
        .Ready   (Ready),
        .Err     (Err),
        .RdCount (RdCount),
        .WrCount (WrCount)
    );

    always #5 Clk1 = ~Clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk1);
        #1;
    endtask

    task automatic idle();
        RD = 0; WR = 0; LdEn = 0; LdDone = 0; ErrClr = 0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        LdEn = 1; LdAddr = a; LdData = d;
        step();
        LdEn = 0;
    endtask

    task automatic bus_rd(input string tag, input logic [15:0] a, input logic [15:0] d);
        RD = 1; WR = 0; Addr = a;
        step();
        exp_rd++;
        chk(tag, DataOut, d);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        WR = 1; RD = 0; Addr = a; DataIn = d;
        step();
        exp_wr++;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_rdcnt"}, RdCount, exp_rd[15:0]);
        chk({tag, "_wrcnt"}, WrCount, exp_wr[15:0]);
    endtask

    initial begin
        Reset = 1; Addr = 0; DataIn = 0; LdAddr = 0; LdData = 0;
        idle();
        #12;
        chk("rst_dataout", DataOut, 16'h0);
        chk("rst_ready", Ready, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk_counts("rst");
        Reset = 0;

        // LOAD phase: preload, ignored bus traffic, out-of-range preload
        preload(16'h0000, 16'h4123);
        preload(16'h0001, 16'hF000);
        preload(16'h0005, 16'h5555);
        preload(16'h0007, 16'h0707);
        RD = 1; WR = 1; Addr = 16'h0005; DataIn = 16'hBEEF;
        step();
        idle();
        chk("load_bus_err", Err, 1'b0);
        chk("load_bus_ready", Ready, 1'b0);
        chk_counts("load_bus");
        preload(16'h2000, 16'hDEAD);
        chk("load_oor_err", Err, 1'b0);

        // LdEn and LdDone together: write still lands, then RUN
        LdEn = 1; LdDone = 1; LdAddr = 16'h0006; LdData = 16'h6666;
        step();
        idle();
        chk("ldone_ready", Ready, 1'b1);
        chk("ldone_err", Err, 1'b0);

        bus_rd("rd_mem0", 16'h0000, 16'h4123);
        chk_counts("first_rd");
        bus_rd("rd_mem1", 16'h0001, 16'hF000);
        bus_rd("rd_mem5", 16'h0005, 16'h5555);
        bus_rd("rd_mem6", 16'h0006, 16'h6666);
        idle();
        step();
        chk("idle_hold", DataOut, 16'h6666);

        // Back-to-back write burst then read burst
        for (int i = 0; i < 16; i++)
            bus_wr(16'h0100 + 16'(i), (16'h0100 + 16'(i)) ^ 16'hA5A5);
        idle();
        chk("wr_burst_hold", DataOut, 16'h6666);
        chk_counts("wr_burst");
        for (int i = 0; i < 16; i++)
            bus_rd("rd_burst", 16'h0100 + 16'(i), (16'h0100 + 16'(i)) ^ 16'hA5A5);
        idle();
        chk_counts("rd_burst");

        bus_wr(16'h0003, 16'h1234);
        bus_rd("wr_then_rd", 16'h0003, 16'h1234);
        idle();

        // Out-of-range read traps; FAULT ignores writes; ErrClr recovers
        RD = 1; Addr = 16'h1000;
        step();
        idle();
        chk("oor_rd_err", Err, 1'b1);
        chk("oor_rd_ready", Ready, 1'b0);
        chk("oor_rd_hold", DataOut, 16'h1234);
        WR = 1; Addr = 16'h0003; DataIn = 16'hBAD0;
        step();
        idle();
        chk("fault_sticky", Err, 1'b1);
        chk_counts("fault_wr");
        ErrClr = 1;
        step();
        idle();
        chk("clr_ready", Ready, 1'b1);
        chk("clr_err", Err, 1'b0);
        bus_rd("fault_wr_dropped", 16'h0003, 16'h1234);
        idle();

        // RD and WR together traps with no access
        RD = 1; WR = 1; Addr = 16'h0007; DataIn = 16'h7777;
        step();
        idle();
        chk("rdwr_err", Err, 1'b1);
        chk("rdwr_hold", DataOut, 16'h1234);
        chk_counts("rdwr");
        ErrClr = 1;
        step();
        idle();
        bus_rd("rdwr_mem7", 16'h0007, 16'h0707);

        // Out-of-range write must not alias onto low memory
        WR = 1; RD = 0; Addr = 16'h1001; DataIn = 16'hFFFF;
        step();
        idle();
        chk("oor_wr_err", Err, 1'b1);
        chk_counts("oor_wr");
        ErrClr = 1;
        step();
        idle();
        bus_rd("oor_wr_alias", 16'h0001, 16'hF000);
        bus_rd("oor_ld_alias", 16'h0000, 16'h4123);
        idle();

        // Async reset during the 8th beat of a write burst
        for (int i = 0; i < 7; i++)
            bus_wr(16'h0200 + 16'(i), 16'hC000 + 16'(i));
        WR = 1; Addr = 16'h0207; DataIn = 16'hC007;
        #3;
        Reset = 1;
        #1;
        chk("async_dataout", DataOut, 16'h0);
        chk("async_ready", Ready, 1'b0);
        chk("async_err", Err, 1'b0);
        chk("async_rdcnt", RdCount, 16'h0);
        chk("async_wrcnt", WrCount, 16'h0);
        idle();
        #2;
        Reset = 0;
        exp_rd = 0;
        exp_wr = 0;
        step();
        chk("post_rst_ready", Ready, 1'b0);
        LdDone = 1;
        step();
        idle();
        chk("post_rst_run", Ready, 1'b1);
        chk_counts("post_rst");
        for (int i = 0; i < 7; i++)
            bus_rd("post_rst_beat", 16'h0200 + 16'(i), 16'hC000 + 16'(i));
        bus_rd("mem_kept", 16'h0000, 16'h4123);
        idle();
        chk_counts("post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cvp14_mem_responder.md
Name: cvp14_mem_responder

Overview:
Single-port system memory that answers the vector processor's Addr/RD/WR/DataIn/DataOut bus. It serves instruction fetches, scalar stores and 16-beat VLD/VST bursts at one word per cycle. A preload port fills the memory with program and data before the processor bus is accepted. Protocol violations are trapped in a sticky fault state.

Parameters:
DW, 16, data word width
AW, 16, address width on bus and preload port
DEPTH, 4096, number of implemented words; addresses >= DEPTH are out of range

Ports:
Clk1  in  1  single clock; all state updates on posedge
Reset  in  1  asynchronous, active-high reset
Addr  in  AW  processor word address
RD  in  1  processor read request, sampled every edge
WR  in  1  processor write request, sampled every edge
DataIn  in  DW  processor write data (the processor's DataOut)
DataOut  out  DW  registered read data (the processor's DataIn)
LdEn  in  1  preload write strobe
LdAddr  in  AW  preload address
LdData  in  DW  preload data
LdDone  in  1  preload complete; enables the processor bus
ErrClr  in  1  leave fault state
Ready  out  1  high in RUN
Err  out  1  high in FAULT
RdCount  out  16  accepted read beats, saturating
WrCount  out  16  accepted write beats, saturating

Behaviour:
- Reset (async, any time, including mid-burst):
  - state=LOAD; DataOut=0, Ready=0, Err=0, RdCount=0, WrCount=0.
  - Memory array contents are NOT cleared.
- States: LOAD, RUN, FAULT. Ready=(state==RUN), Err=(state==FAULT); both are registered state decodes.
- LOAD:
  - RD/WR are ignored: no access, no count, no fault.
  - LdEn=1 and LdAddr<DEPTH: mem[LdAddr]<=LdData. Out-of-range preload is silently dropped.
  - LdDone=1 -> RUN next edge. If LdEn and LdDone are both high in the same cycle, the write is performed and the transition still occurs.
- RUN, evaluated each edge:
  - RD=1, WR=0, Addr<DEPTH: DataOut<=mem[Addr]; RdCount++.
    - Read latency is one cycle: data requested at edge t is visible after edge t.
    - RD held high with a new Addr every cycle gives one word per cycle (VLD burst).
  - WR=1, RD=0, Addr<DEPTH: mem[Addr]<=DataIn; WrCount++. DataOut holds its value.
    - A read of the same address on the next cycle returns the new data.
  - RD=0, WR=0: idle; DataOut holds its last value.
  - RD=1 and WR=1: no access, no count, DataOut unchanged -> FAULT.
  - (RD or WR) and Addr>=DEPTH: no access, no count, DataOut unchanged -> FAULT.
  - LdEn and LdDone are ignored.
- FAULT:
  - All bus and preload activity is ignored; DataOut holds; counters hold.
  - ErrClr=1 -> RUN next edge. ErrClr in LOAD or RUN has no effect.
- Counters: 16-bit, saturate at 16'hFFFF and do not wrap. Cleared only by Reset.
- Memory is inferred as a synchronous single-port array. Preload and processor accesses are never simultaneous, because they are gated by state.

Test Plan:
1. Reset, then preload mem[0]=16'h4123 and mem[1]=16'hF000, then LdDone; RD=1, Addr=0 -> Ready=1 after one edge; DataOut=16'h4123 one cycle after the read edge; RdCount=1.
2. Burst write: WR=1, Addr=16'h0100..16'h010F, DataIn=Addr^16'hA5A5, one beat per cycle; then RD burst over the same range -> each DataOut equals Addr^16'hA5A5, one cycle after its address; WrCount=16, RdCount=16.
3. In LOAD, RD=1 and WR=1 with Addr=5 -> no fault, counters stay 0, mem[5] unchanged; LdEn with LdAddr=16'h2000 -> no write and Err stays 0.
4. In RUN, RD=1 with Addr=16'h1000 (DEPTH=4096) -> Err=1 next edge, DataOut unchanged; a WR to Addr=3 while in FAULT leaves mem[3] unchanged; ErrClr -> Ready=1 next edge.
5. In RUN, RD=1 and WR=1 together at Addr=7 -> FAULT; mem[7] unchanged; WrCount and RdCount unchanged.
6. Assert Reset asynchronously mid-burst (8th beat of a write burst) -> outputs are 0 immediately and state is LOAD; after LdDone, reading beats 1-7 returns the data written; beat 8 holds the old or new value depending on whether its edge was reached; counters are 0 before the new reads.
